serial_adder: RTL and testbench

- Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock.
- Carry is held in a flip-flop between digits, so a narrow full-adder slice is reused across the word.
- Sits in the adders library as the sequential successor to the combinational 1-bit full adder.
- Trades latency for area; start/busy/done handshake toward a controller.

---
 rtl/serial_adder_if.sv | 33 +++
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// Optional subtract request (sub) exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a + b + c_in, DIGIT bits per clock, start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add a subtract request (bus.sub) computing a - b.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be a positive multiple of DIGIT and DIGIT <= WIDTH");
    end
  endgenerate

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             c_out_q;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   digit_res;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic             last;

  always_comb begin
    digit_res = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    last      = (cnt == CW'(N - 1));
  end

  // Each digit result enters from the MSB side so the word is aligned after N digits.
  generate
    if (DIGIT == WIDTH) begin : g_single_digit
      assign sum_next = digit_res[DIGIT-1:0];
    end else begin : g_multi_digit
      assign sum_next = {digit_res[DIGIT-1:0], sum_sh[WIDTH-1:DIGIT]};
    end
  endgenerate

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert b and force the carry-in to 1.
  assign b_load     = bus.sub ? ~bus.b : bus.b;
  assign carry_load = bus.sub | bus.c_in;
`else
  assign b_load     = bus.b;
  assign carry_load = bus.c_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      sum_q   <= '0;
      carry   <= 1'b0;
      c_out_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          sum_sh <= sum_next;
          carry  <= digit_res[DIGIT];
          cnt    <= cnt + CW'(1);
          if (last) begin
            sum_q   <= sum_next;
            c_out_q <= digit_res[DIGIT];
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: lanes 8/1 and 16/4, plus 8/2 subtract lane
// when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
`ifdef SERIAL_ADDER_SUB_EN
  localparam int NL = 3;
`else
  localparam int NL = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic chk_en = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic        st[NL];
  logic [15:0] av[NL];
  logic [15:0] bv[NL];
  logic        cv[NL];
  logic        sv[NL];
  logic        ob[NL];
  logic        od[NL];
  logic        oc[NL];
  logic [15:0] os[NL];

  int          rem[NL];
  logic [15:0] pend[NL];
  logic [15:0] msum[NL];
  logic        pc[NL];
  logic        mc[NL];
  logic        md[NL];

  int cyc, nb, nd;

  logic [15:0] ta[4] = '{16'hFFFF, 16'h1234, 16'h8000, 16'hABCD};
  logic [15:0] tbv[4] = '{16'h0001, 16'h4321, 16'h8000, 16'h1111};
  logic        tc[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] es[4] = '{16'h0001, 16'h5555, 16'h0001, 16'hBCDE};
  logic        ec[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  if0 ();
  serial_adder_if #(.WIDTH(16)) if1 ();

  assign if0.start = st[0];
  assign if0.a     = av[0][7:0];
  assign if0.b     = bv[0][7:0];
  assign if0.c_in  = cv[0];
  assign ob[0]     = if0.busy;
  assign od[0]     = if0.done;
  assign oc[0]     = if0.c_out;
  assign os[0]     = {8'h00, if0.sum};

  assign if1.start = st[1];
  assign if1.a     = av[1];
  assign if1.b     = bv[1];
  assign if1.c_in  = cv[1];
  assign ob[1]     = if1.busy;
  assign od[1]     = if1.done;
  assign oc[1]     = if1.c_out;
  assign os[1]     = if1.sum;

  serial_adder #(.WIDTH(8),  .DIGIT(1)) u_w8d1  (.clk(clk), .rst_n(rst_n), .bus(if0));
  serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16d4 (.clk(clk), .rst_n(rst_n), .bus(if1));

`ifdef SERIAL_ADDER_SUB_EN
  serial_adder_if #(.WIDTH(8)) if2 ();
  assign if0.sub   = sv[0];
  assign if1.sub   = sv[1];
  assign if2.start = st[2];
  assign if2.a     = av[2][7:0];
  assign if2.b     = bv[2][7:0];
  assign if2.c_in  = cv[2];
  assign if2.sub   = sv[2];
  assign ob[2]     = if2.busy;
  assign od[2]     = if2.done;
  assign oc[2]     = if2.c_out;
  assign os[2]     = {8'h00, if2.sum};
  serial_adder #(.WIDTH(8), .DIGIT(2)) u_w8d2 (.clk(clk), .rst_n(rst_n), .bus(if2));
`endif

  function automatic int lane_w(int i);
    return (i == 1) ? 16 : 8;
  endfunction

  function automatic int lane_n(int i);
    return (i == 0) ? 8 : 4;
  endfunction

  // {carry/no-borrow, result} straight from integer arithmetic
  function automatic logic [16:0] ref_result(int i);
    longint unsigned m = 64'd1 << lane_w(i);
    longint unsigned x = 64'(av[i]) % m;
    longint unsigned y = 64'(bv[i]) % m;
    longint unsigned t;
    if (sv[i]) begin
      t = (x + m - y) % m;
      return {x >= y, t[15:0]};
    end
    t = x + y + 64'(cv[i]);
    return {t >= m, 16'(t % m)};
  endfunction

  // Timing model: result appears N edges after acceptance, done for one cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) begin
        rem[i]  <= 0;
        pend[i] <= '0;
        pc[i]   <= 1'b0;
        msum[i] <= '0;
        mc[i]   <= 1'b0;
        md[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NL; i++) begin
        md[i] <= (rem[i] == 1);
        if (rem[i] == 1) begin
          msum[i] <= pend[i];
          mc[i]   <= pc[i];
        end
        if (rem[i] > 0) begin
          rem[i] <= rem[i] - 1;
        end else if (st[i]) begin
          rem[i]           <= lane_n(i);
          {pc[i], pend[i]} <= ref_result(i);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NL; i++) begin
        check($sformatf("busy%0d", i), 32'(ob[i]), 32'(rem[i] > 0));
        check($sformatf("done%0d", i), 32'(od[i]), 32'(md[i]));
        check($sformatf("sum%0d", i),  32'(os[i]), 32'(msum[i]));
        check($sformatf("cout%0d", i), 32'(oc[i]), 32'(mc[i]));
      end
    end
  end

  task automatic op(input int ln, input logic [15:0] x, input logic [15:0] y,
                    input logic ci, input logic s, output int c, output int b);
    st[ln] = 1'b1;
    av[ln] = x;
    bv[ln] = y;
    cv[ln] = ci;
    sv[ln] = s;
    @(negedge clk);
    st[ln] = 1'b0;
    c = 1;
    b = int'(ob[ln]);
    while (!od[ln] && c < 40) begin
      @(negedge clk);
      c++;
      b += int'(ob[ln]);
    end
    check($sformatf("timeout%0d", ln), 32'(od[ln]), 32'd1);
  endtask

  task automatic chk_res(input string nm, input int ln, input logic [15:0] s, input logic c);
    check({nm, "_sum"},  32'(os[ln]), 32'(s));
    check({nm, "_cout"}, 32'(oc[ln]), 32'(c));
  endtask

  initial begin
    for (int i = 0; i < NL; i++) begin
      st[i] = 1'b0; av[i] = '0; bv[i] = '0; cv[i] = 1'b0; sv[i] = 1'b0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_busy", 32'(ob[0]), 32'd0);
    check("rst_done", 32'(od[0]), 32'd0);
    chk_res("rst", 0, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // zero operands: 8 busy cycles, done 9 cycles after accept
    op(0, 16'h00, 16'h00, 1'b0, 1'b0, cyc, nb);
    check("t1_lat", 32'(cyc), 32'd9);
    check("t1_busy", 32'(nb), 32'd8);
    chk_res("t1", 0, 16'h00, 1'b0);
    @(negedge clk);

    op(0, 16'hFF, 16'h01, 1'b0, 1'b0, cyc, nb);
    check("t2a_lat", 32'(cyc), 32'd9);
    chk_res("t2a", 0, 16'h00, 1'b1);
    // back-to-back start issued on the done cycle
    op(0, 16'hA5, 16'h5A, 1'b1, 1'b0, cyc, nb);
    check("t2b_lat", 32'(cyc), 32'd9);
    check("t2b_busy", 32'(nb), 32'd8);
    chk_res("t2b", 0, 16'h00, 1'b1);
    @(negedge clk);
    @(negedge clk);

    // start held high while busy with different operands must be ignored
    st[0] = 1'b1; av[0] = 16'h12; bv[0] = 16'h34; cv[0] = 1'b0;
    nd = 0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (j <= 4) begin
        av[0] = 16'hFF;
        bv[0] = 16'hFF;
      end else begin
        st[0] = 1'b0;
      end
      nd += int'(od[0]);
    end
    check("t3_ndone", 32'(nd), 32'd1);
    chk_res("t3", 0, 16'h46, 1'b0);

    // reset in flight
    st[0] = 1'b1; av[0] = 16'h80; bv[0] = 16'h80; cv[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_busy", 32'(ob[0]), 32'd0);
    check("t4_done", 32'(od[0]), 32'd0);
    chk_res("t4_rst", 0, 16'h00, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      nd += int'(od[0]);
    end
    check("t4_nodone", 32'(nd), 32'd0);
    op(0, 16'h03, 16'h04, 1'b0, 1'b0, cyc, nb);
    chk_res("t4_next", 0, 16'h07, 1'b0);
    @(negedge clk);
    op(0, 16'h7F, 16'h01, 1'b1, 1'b0, cyc, nb);
    chk_res("t4_b", 0, 16'h81, 1'b0);
    @(negedge clk);

    // 16-bit, 4 bits per clock
    for (int k = 0; k < 4; k++) begin
      op(1, ta[k], tbv[k], tc[k], 1'b0, cyc, nb);
      check($sformatf("w16_lat%0d", k), 32'(cyc), 32'd5);
      check($sformatf("w16_busy%0d", k), 32'(nb), 32'd4);
      chk_res($sformatf("w16_%0d", k), 1, es[k], ec[k]);
      @(negedge clk);
    end

`ifdef SERIAL_ADDER_SUB_EN
    op(2, 16'h05, 16'h07, 1'b0, 1'b1, cyc, nb);
    check("sub_lat", 32'(cyc), 32'd5);
    chk_res("sub_a", 2, 16'hFE, 1'b0);
    @(negedge clk);
    op(2, 16'h07, 16'h05, 1'b1, 1'b1, cyc, nb);
    chk_res("sub_b", 2, 16'h02, 1'b1);
    @(negedge clk);
    op(2, 16'h05, 16'h07, 1'b1, 1'b0, cyc, nb);
    chk_res("sub_add", 2, 16'h0D, 1'b0);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
